// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: collects two decimal operands and an operator, then hands them to an arithmetic unit.
// Define CALC_CHAIN_EN to add the result port and chain each result into operand 1 of the next calculation.
module calc_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        busy_a,
    input  logic        busy_p,
    output logic        key_ready,
    output logic [26:0] data1,
    output logic [26:0] data2,
    output logic [2:0]  arith,
    output logic        en,
    output logic        ovf
`ifdef CALC_CHAIN_EN
    ,
    input  logic [26:0] result
`endif
);

    typedef enum logic [2:0] {OP1, OP2, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t      state, state_n;
    logic [26:0] data1_n, data2_n;
    logic [2:0]  arith_n;
    logic        ovf_n;
    logic [3:0]  cnt1, cnt1_n, cnt2, cnt2_n;
    logic [3:0]  tmo, tmo_n;
    logic        wait_op, wait_op_n;
    logic        accept, is_digit, is_op, is_equals, is_clear;
    logic [2:0]  op_code;
    logic [26:0] digit;

    // key_ready is forced low while reset is held even though state already reads OP1
    assign key_ready = rst_n && (state == OP1 || state == OP2) && !busy_a && !busy_p;
    assign accept    = key_valid && key_ready;
    assign en        = (state == ISSUE);
    assign is_digit  = (key_code <= 4'd9);
    assign is_op     = (key_code >= 4'd10) && (key_code <= 4'd13);
    assign is_equals = (key_code == 4'd14);
    assign is_clear  = (key_code == 4'd15);
    assign digit     = {23'd0, key_code};

    always_comb begin
        case (key_code)
            4'd10:   op_code = 3'b000;
            4'd11:   op_code = 3'b001;
            4'd12:   op_code = 3'b010;
            default: op_code = 3'b011;
        endcase
    end

    always_comb begin
        state_n   = state;
        data1_n   = data1;
        data2_n   = data2;
        arith_n   = arith;
        ovf_n     = ovf;
        cnt1_n    = cnt1;
        cnt2_n    = cnt2;
        tmo_n     = tmo;
        wait_op_n = wait_op;
        if (accept && is_clear) begin
            state_n   = OP1;
            data1_n   = '0;
            data2_n   = '0;
            arith_n   = '0;
            ovf_n     = 1'b0;
            cnt1_n    = '0;
            cnt2_n    = '0;
            wait_op_n = 1'b0;
        end else begin
            case (state)
                OP1: if (accept) begin
                    if (is_digit) begin
                        if (cnt1 == 4'd8) ovf_n = 1'b1;
                        else begin
                            data1_n = data1 * 27'd10 + digit;
                            cnt1_n  = cnt1 + 4'd1;
                        end
                    end else if (is_op) begin
                        arith_n = op_code;
                        state_n = OP2;
                    end
                end
                OP2: if (accept) begin
                    // A chained result sits in data1 until an operator arrives; digits and equals are ignored
                    if (wait_op) begin
                        if (is_op) begin
                            arith_n   = op_code;
                            wait_op_n = 1'b0;
                        end
                    end else if (is_digit) begin
                        if (cnt2 == 4'd8) ovf_n = 1'b1;
                        else begin
                            data2_n = data2 * 27'd10 + digit;
                            cnt2_n  = cnt2 + 4'd1;
                        end
                    end else if (is_op) begin
                        if (cnt2 == 4'd0) arith_n = op_code;
                    end else if (is_equals) begin
                        state_n = ISSUE;
                    end
                end
                ISSUE: begin
                    state_n = WAIT_HI;
                    tmo_n   = '0;
                end
                WAIT_HI: begin
                    if (busy_a || tmo == 4'd15) state_n = WAIT_LO;
                    else tmo_n = tmo + 4'd1;
                end
                WAIT_LO: if (!busy_a && !busy_p) begin
                    data2_n = '0;
                    arith_n = '0;
                    cnt1_n  = '0;
                    cnt2_n  = '0;
`ifdef CALC_CHAIN_EN
                    data1_n   = result;
                    wait_op_n = 1'b1;
                    state_n   = OP2;
`else
                    data1_n = '0;
                    state_n = OP1;
`endif
                end
                default: state_n = OP1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= OP1;
            data1   <= '0;
            data2   <= '0;
            arith   <= '0;
            ovf     <= 1'b0;
            cnt1    <= '0;
            cnt2    <= '0;
            tmo     <= '0;
            wait_op <= 1'b0;
        end else begin
            state   <= state_n;
            data1   <= data1_n;
            data2   <= data2_n;
            arith   <= arith_n;
            ovf     <= ovf_n;
            cnt1    <= cnt1_n;
            cnt2    <= cnt2_n;
            tmo     <= tmo_n;
            wait_op <= wait_op_n;
        end
    end

endmodule
